// File: rtl/uart_pkg.sv
// Shared types and constants for the parameterised UART transmitter:
// FSM state encoding, parity-select codes and baud ticks per bit.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP1,
      ST_STOP2,
      ST_BREAK
   } tx_state_t;

   localparam logic [1:0] PDSEL_NONE  = 2'b00;
   localparam logic [1:0] PDSEL_EVEN  = 2'b01;
   localparam logic [1:0] PDSEL_ODD   = 2'b10;
   localparam logic [1:0] PDSEL_NONE2 = 2'b11;

   localparam int TICKS_BRGH = 4;
   localparam int TICKS_STD  = 16;

   // Frame settings captured when a character is popped.
   typedef struct packed {
      logic       brgh;
      logic [1:0] pdsel;
      logic       stsel;
   } tx_cfg_t;

   function automatic logic [3:0] last_tick(input logic brgh);
      return brgh ? 4'(TICKS_BRGH - 1) : 4'(TICKS_STD - 1);
   endfunction

   function automatic logic has_parity(input logic [1:0] pdsel);
      return (pdsel == PDSEL_EVEN) || (pdsel == PDSEL_ODD);
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO with occupancy count; head entry is visible on rd_data
// without a read request so the transmitter can pop straight into its shifter.
module uart_tx_fifo #(
   parameter  int DATA_W     = 8,
   parameter  int FIFO_DEPTH = 4,
   localparam int AW         = $clog2(FIFO_DEPTH),
   localparam int LW         = AW + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_en,
   output logic [DATA_W-1:0] rd_data,
   output logic              full,
   output logic              empty,
   output logic [LW-1:0]     level
);

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_reg, wr_ptr_next;
   logic [AW-1:0]     rd_ptr_reg, rd_ptr_next;
   logic [LW-1:0]     level_reg, level_next;

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr_reg] <= wr_data;
   end

   // Depth is a power of two, so pointer overflow is the modulo wrap.
   always_comb begin
      wr_ptr_next = wr_ptr_reg;
      rd_ptr_next = rd_ptr_reg;
      level_next  = level_reg;
      if (wr_en)
         wr_ptr_next = wr_ptr_reg + 1'b1;
      if (rd_en)
         rd_ptr_next = rd_ptr_reg + 1'b1;
      if (wr_en && !rd_en)
         level_next = level_reg + 1'b1;
      else if (!wr_en && rd_en)
         level_next = level_reg - 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         wr_ptr_reg <= wr_ptr_next;
         rd_ptr_reg <= rd_ptr_next;
         level_reg  <= level_next;
      end
   end

   assign rd_data = mem[rd_ptr_reg];
   assign full    = (level_reg == LW'(FIFO_DEPTH));
   assign empty   = (level_reg == '0);
   assign level   = level_reg;

endmodule

// File: rtl/uart_tx_param.sv
// Parameterised UART transmitter with FIFO, parity, 1/2 stop bits and break.
// Define UART_TX_CTS_EN to gate frame starts on a synchronised cts_i.
module uart_tx_param
   import uart_pkg::*;
#(
   parameter  int DATA_W     = 8,
   parameter  int FIFO_DEPTH = 4,
   localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_valid_i,
   input  logic [DATA_W-1:0] tx_data_i,
   output logic              tx_ready_o,
   input  logic              txbrk_i,
   input  logic              enable_i,
   input  logic              brg_sample_i,
   input  logic              brgh_i,
   input  logic [1:0]        pdsel_i,
   input  logic              stsel_i,
   input  logic              cts_i,
   output logic              txd_o,
   output logic [LW-1:0]     fifo_level_o,
   output logic              tx_empty_o
);

   tx_state_t         state_reg, state_next;
   logic [3:0]        tick_cnt_reg, tick_cnt_next;
   logic [3:0]        bit_cnt_reg, bit_cnt_next;
   logic [DATA_W-1:0] shift_reg, shift_next;
   logic              parity_reg, parity_next;
   tx_cfg_t           cfg_reg, cfg_next;

   logic              fifo_full, fifo_empty, pop, start_ok, bit_end;
   logic [DATA_W-1:0] fifo_rd_data;

`ifdef UART_TX_CTS_EN
   logic [1:0] cts_sync_reg;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cts_sync_reg <= '0;
      else
         cts_sync_reg <= {cts_sync_reg[0], cts_i};
   end
   assign start_ok = cts_sync_reg[1];
`else
   logic unused_cts;
   assign unused_cts = cts_i;
   assign start_ok   = 1'b1;
`endif

   uart_tx_fifo #(
      .DATA_W     (DATA_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (tx_valid_i & ~fifo_full),
      .wr_data (tx_data_i),
      .rd_en   (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .level   (fifo_level_o)
   );

   assign bit_end = enable_i & brg_sample_i & (tick_cnt_reg == last_tick(cfg_reg.brgh));

   always_comb begin
      state_next    = state_reg;
      tick_cnt_next = tick_cnt_reg;
      bit_cnt_next  = bit_cnt_reg;
      shift_next    = shift_reg;
      parity_next   = parity_reg;
      cfg_next      = cfg_reg;
      pop           = 1'b0;

      if (state_reg == ST_IDLE)
         tick_cnt_next = '0;
      else if (enable_i && brg_sample_i)
         tick_cnt_next = bit_end ? 4'd0 : tick_cnt_reg + 4'd1;

      case (state_reg)
         ST_IDLE: begin
            if (enable_i && !fifo_empty && start_ok) begin
               pop           = 1'b1;
               shift_next    = fifo_rd_data;
               parity_next   = (^fifo_rd_data) ^ (pdsel_i == PDSEL_ODD);
               cfg_next.brgh  = brgh_i;
               cfg_next.pdsel = pdsel_i;
               cfg_next.stsel = stsel_i;
               bit_cnt_next  = '0;
               // A break consumes the popped character without sending it.
               state_next    = txbrk_i ? ST_BREAK : ST_START;
            end
         end
         ST_START: begin
            if (bit_end)
               state_next = ST_DATA;
         end
         ST_DATA: begin
            if (bit_end) begin
               shift_next = shift_reg >> 1;
               if (bit_cnt_reg == 4'(DATA_W - 1))
                  state_next = has_parity(cfg_reg.pdsel) ? ST_PARITY : ST_STOP1;
               else
                  bit_cnt_next = bit_cnt_reg + 4'd1;
            end
         end
         ST_PARITY: begin
            if (bit_end)
               state_next = ST_STOP1;
         end
         ST_STOP1: begin
            if (bit_end)
               state_next = cfg_reg.stsel ? ST_STOP2 : ST_IDLE;
         end
         ST_STOP2: begin
            if (bit_end)
               state_next = ST_IDLE;
         end
         ST_BREAK: begin
            if (bit_end) begin
               if (bit_cnt_reg == 4'(DATA_W + 1))
                  state_next = ST_STOP1;
               else
                  bit_cnt_next = bit_cnt_reg + 4'd1;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         tick_cnt_reg <= '0;
         bit_cnt_reg  <= '0;
         shift_reg    <= '0;
         parity_reg   <= 1'b0;
         cfg_reg      <= '0;
      end else begin
         state_reg    <= state_next;
         tick_cnt_reg <= tick_cnt_next;
         bit_cnt_reg  <= bit_cnt_next;
         shift_reg    <= shift_next;
         parity_reg   <= parity_next;
         cfg_reg      <= cfg_next;
      end
   end

   // Line level decoded from state so reset returns it high without a clock.
   always_comb begin
      txd_o = 1'b1;
      case (state_reg)
         ST_START, ST_BREAK: txd_o = 1'b0;
         ST_DATA:            txd_o = shift_reg[0];
         ST_PARITY:          txd_o = parity_reg;
         default:            txd_o = 1'b1;
      endcase
   end

   assign tx_ready_o = ~fifo_full;
   assign tx_empty_o = fifo_empty & (state_reg == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed bench for uart_tx_param: frame vectors on 8- and 7-bit instances,
// FIFO full/back-to-back, break, enable freeze, mid-frame reset and CTS gating.
module tb_uart_tx_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, brg, brg_run, tog, enable, txbrk, brgh, cts;
   logic       v8, rdy8, txd8, emp8, st8;
   logic [7:0] d8;
   logic [1:0] pd8;
   logic [2:0] lvl8;
   logic       v7, rdy7, txd7, emp7, st7;
   logic [6:0] d7;
   logic [1:0] pd7;
   logic [2:0] lvl7;

   int errors = 0;
   int checks = 0;

   uart_tx_param #(.DATA_W(8), .FIFO_DEPTH(4)) u8 (
      .clk(clk), .rst(rst), .tx_valid_i(v8), .tx_data_i(d8), .tx_ready_o(rdy8),
      .txbrk_i(txbrk), .enable_i(enable), .brg_sample_i(brg), .brgh_i(brgh),
      .pdsel_i(pd8), .stsel_i(st8), .cts_i(cts), .txd_o(txd8),
      .fifo_level_o(lvl8), .tx_empty_o(emp8));

   uart_tx_param #(.DATA_W(7), .FIFO_DEPTH(4)) u7 (
      .clk(clk), .rst(rst), .tx_valid_i(v7), .tx_data_i(d7), .tx_ready_o(rdy7),
      .txbrk_i(1'b0), .enable_i(enable), .brg_sample_i(brg), .brgh_i(brgh),
      .pdsel_i(pd7), .stsel_i(st7), .cts_i(cts), .txd_o(txd7),
      .fifo_level_o(lvl7), .tx_empty_o(emp7));

   // Baud tick every second cycle; brg_run can stall the bit timer.
   initial begin
      tog = 1'b0;
      brg = 1'b0;
      forever begin
         @(negedge clk);
         tog = ~tog;
         brg = tog & brg_run;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic cur_txd(input bit use7);
      return use7 ? txd7 : txd8;
   endfunction

   // Waits for the start bit, then samples nbits mid-bit (LSB of bits = start).
   task automatic decode(input bit use7, input int nbits, input int bitc,
                         output logic [11:0] bits, output int wait_cyc);
      bits = '0;
      wait_cyc = 0;
      while (cur_txd(use7) !== 1'b0 && wait_cyc < 3000) begin
         @(negedge clk);
         wait_cyc++;
      end
      if (wait_cyc >= 3000) begin
         checks++;
         errors++;
         $display("FAIL start_timeout: got no start bit expected start within 3000 cycles");
         return;
      end
      repeat (bitc / 2) @(negedge clk);
      for (int i = 0; i < nbits; i++) begin
         bits[i] = cur_txd(use7);
         if (i < nbits - 1)
            repeat (bitc) @(negedge clk);
      end
      $display("frame %s: bits=%03h after %0d idle cycles", use7 ? "u7" : "u8", bits, wait_cyc);
   endtask

   task automatic push8(input logic [7:0] d);
      int n = 0;
      while (!rdy8 && n < 500) begin
         @(negedge clk);
         n++;
      end
      check("push8_ready", 32'(rdy8), 32'd1);
      v8 = 1'b1;
      d8 = d;
      @(negedge clk);
      v8 = 1'b0;
      $display("write u8 data=%02h", d);
   endtask

   task automatic wait_empty8(input string name, input int limit);
      int n = 0;
      while (!emp8 && n < limit) begin
         @(negedge clk);
         n++;
      end
      check(name, 32'(emp8), 32'd1);
   endtask

   typedef struct {
      logic [7:0]  data;
      logic [1:0]  pdsel;
      logic        stsel;
      logic        brgh;
      int          nbits;
      logic [11:0] exp;
   } vec_t;

   vec_t        vecs[6];
   logic [11:0] bits;
   logic [7:0]  burst[6];
   int          w, acc, bitc, n;

   initial begin
      // Expected frames, LSB = start bit, written out by hand.
      vecs[0] = '{8'h55, 2'b00, 1'b0, 1'b1, 10, 12'h2AA};
      vecs[1] = '{8'hA5, 2'b01, 1'b0, 1'b1, 11, 12'h54A};
      vecs[2] = '{8'h01, 2'b10, 1'b1, 1'b1, 12, 12'hC02};
      vecs[3] = '{8'hFF, 2'b01, 1'b0, 1'b1, 11, 12'h5FE};
      vecs[4] = '{8'h80, 2'b11, 1'b1, 1'b1, 11, 12'h700};
      vecs[5] = '{8'h3C, 2'b00, 1'b0, 1'b0, 10, 12'h278};
      burst   = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};

      rst = 1'b1; brg_run = 1'b1; enable = 1'b1; txbrk = 1'b0; brgh = 1'b1; cts = 1'b1;
      v8 = 1'b0; d8 = '0; pd8 = 2'b00; st8 = 1'b0;
      v7 = 1'b0; d7 = '0; pd7 = 2'b00; st7 = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_txd", 32'(txd8), 32'd1);
      check("reset_ready", 32'(rdy8), 32'd1);
      check("reset_level", 32'(lvl8), 32'd0);
      check("reset_empty", 32'(emp8), 32'd1);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      for (int i = 0; i < 6; i++) begin
         pd8 = vecs[i].pdsel; st8 = vecs[i].stsel; brgh = vecs[i].brgh;
         bitc = (vecs[i].brgh ? 4 : 16) * 2;
         push8(vecs[i].data);
         decode(1'b0, vecs[i].nbits, bitc, bits, w);
         check($sformatf("vec%0d_frame", i), 32'(bits), 32'(vecs[i].exp));
         repeat (bitc) @(negedge clk);
         check($sformatf("vec%0d_empty", i), 32'(emp8), 32'd1);
      end

      // 7-bit instance, odd parity, two stop bits.
      brgh = 1'b1; pd7 = 2'b10; st7 = 1'b1;
      v7 = 1'b1; d7 = 7'h03;
      @(negedge clk);
      v7 = 1'b0;
      $display("write u7 data=03");
      decode(1'b1, 11, 8, bits, w);
      check("u7_frame", 32'(bits), 32'h706);
      repeat (8) @(negedge clk);
      check("u7_empty", 32'(emp7), 32'd1);

      // Six writes while the shifter is busy and ticks are stalled.
      pd8 = 2'b00; st8 = 1'b0; brg_run = 1'b0;
      acc = 0;
      for (int i = 0; i < 6; i++) begin
         v8 = 1'b1;
         d8 = burst[acc];
         if (rdy8) begin
            $display("write u8 data=%02h", burst[acc]);
            acc++;
         end
         @(negedge clk);
      end
      v8 = 1'b0;
      check("burst_accepted", 32'(acc), 32'd5);
      check("burst_ready", 32'(rdy8), 32'd0);
      check("burst_level", 32'(lvl8), 32'd4);
      brg_run = 1'b1;
      for (int k = 0; k < 5; k++) begin
         decode(1'b0, 10, 8, bits, w);
         check($sformatf("burst%0d_frame", k), 32'(bits), 32'({1'b1, burst[k], 1'b0}));
         if (k > 0)
            check($sformatf("burst%0d_gap_ok", k), 32'(w <= 6), 32'd1);
      end
      wait_empty8("burst_done", 200);

      // Break with one queued entry.
      enable = 1'b0;
      push8(8'hC3);
      check("brk_level_queued", 32'(lvl8), 32'd1);
      txbrk = 1'b1; enable = 1'b1;
      decode(1'b0, 11, 8, bits, w);
      txbrk = 1'b0;
      check("brk_frame", 32'(bits), 32'h400);
      repeat (24) @(negedge clk);
      check("brk_level", 32'(lvl8), 32'd0);
      check("brk_idle_txd", 32'(txd8), 32'd1);
      check("brk_empty", 32'(emp8), 32'd1);

      // Enable low during data bit 0 (a '1') freezes the line.
      push8(8'h0F);
      n = 0;
      while (txd8 && n < 100) begin @(negedge clk); n++; end
      repeat (12) @(negedge clk);
      enable = 1'b0;
      repeat (40) @(negedge clk);
      check("freeze_txd", 32'(txd8), 32'd1);
      check("freeze_busy", 32'(emp8), 32'd0);
      enable = 1'b1;
      wait_empty8("freeze_resume_done", 200);

      // Reset in the middle of a data bit discards everything.
      push8(8'h00); push8(8'h00); push8(8'h00);
      n = 0;
      while (txd8 && n < 100) begin @(negedge clk); n++; end
      repeat (12) @(negedge clk);
      check("rst_pre_txd", 32'(txd8), 32'd0);
      #2 rst = 1'b1;
      #1;
      check("rst_async_txd", 32'(txd8), 32'd1);
      check("rst_async_level", 32'(lvl8), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      push8(8'h5A);
      decode(1'b0, 10, 8, bits, w);
      check("rst_after_frame", 32'(bits), 32'h2B4);
      repeat (40) @(negedge clk);
      check("rst_after_empty", 32'(emp8), 32'd1);

`ifdef UART_TX_CTS_EN
      cts = 1'b0;
      repeat (4) @(negedge clk);
      push8(8'hA5);
      repeat (40) @(negedge clk);
      check("cts_block_txd", 32'(txd8), 32'd1);
      check("cts_block_level", 32'(lvl8), 32'd1);
      cts = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (txd8 && n < 20);
      check("cts_start_latency", 32'(n), 32'd3);
      cts = 1'b0;
      wait_empty8("cts_frame_done", 200);
      check("cts_level", 32'(lvl8), 32'd0);
      cts = 1'b1;
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_param.md
UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 Param DATA_W, default 8, data bits per frame, legal range 5..9.
REQ-002 Param FIFO_DEPTH, default 4, TX FIFO entries, power of 2, range 2..16.
REQ-003 Clock and reset shall be: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  block clock, all state on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 tx_valid_i  in  1  write request into TX FIFO.
REQ-007 tx_data_i  in  DATA_W  character to send.
REQ-008 tx_ready_o  out  1  FIFO not full; a write occurs when tx_valid_i & tx_ready_o.
REQ-009 txbrk_i  in  1  send break instead of the next character.
REQ-010 enable_i  in  1  transmitter enable; low freezes the bit timer and FSM.
REQ-011 brg_sample_i  in  1  one-cycle baud-generator tick.
REQ-012 brgh_i  in  1  1: 4 ticks per bit; 0: 16 ticks per bit.
REQ-013 pdsel_i  in  2  00 none, 01 even, 10 odd, 11 none.
REQ-014 stsel_i  in  1  0: one stop bit; 1: two stop bits.
REQ-015 cts_i  in  1  clear-to-send, active-high, asynchronous.
REQ-016 txd_o  out  1  serial output, idle high.
REQ-017 fifo_level_o  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
REQ-018 tx_empty_o  out  1  FIFO empty and FSM in IDLE.

Function
REQ-019 FSM states shall be IDLE, START, DATA, PARITY, STOP1, STOP2, BREAK.
REQ-020 Bit timer: 4-bit counter, cleared in IDLE, incremented on brg_sample_i & enable_i; bit_end occurs on the tick that reaches 3 (brgh_i=1) or 15 (brgh_i=0).
REQ-021 IDLE->START when enable_i & FIFO non-empty & start_ok; the FIFO entry is popped in the same cycle into the shift register.
REQ-022 If txbrk_i is high at that cycle, the FSM shall enter BREAK instead of START and discard the popped entry.
REQ-023 START drives 0 for one bit time, then goes to DATA.
REQ-024 DATA shifts LSB first for DATA_W bit times, then goes to PARITY if pdsel_i is 01 or 10, else to STOP1.
REQ-025 Parity bit: even = XOR of data bits; odd = inverted XOR; computed at pop time.
REQ-026 STOP1 drives 1 for one bit time, then goes to STOP2 if stsel_i=1, else to IDLE.
REQ-027 STOP2 drives 1 for one bit time, then goes to IDLE.
REQ-028 BREAK drives 0 for DATA_W+2 bit times, then goes to STOP1.
REQ-029 Back-to-back frames: an IDLE->START transition is allowed on the cycle after STOP exit, with no extra idle bit.
REQ-030 pdsel_i, stsel_i and brgh_i are sampled at frame start and held for the whole frame.
REQ-031 A write to a full FIFO is impossible (tx_ready_o=0); a write and a pop in the same cycle keep the level unchanged.
REQ-032 enable_i low mid-frame holds the state, counter and txd_o until enable_i returns high.
REQ-033 Write and pop pointers wrap modulo FIFO_DEPTH.

Reset
REQ-034 On rst: FSM=IDLE, counter=0, FIFO empty, txd_o=1, tx_ready_o=1, fifo_level_o=0, tx_empty_o=1.
REQ-035 Reset asserted mid-frame shall force txd_o=1 asynchronously and discard all queued data.

Configuration
REQ-036 Macro UART_TX_CTS_EN.
- Defined: cts_i passes through a 2-FF synchroniser (reset to 0); start_ok = synchronised cts.
- Not defined: start_ok = 1 and cts_i is ignored.
REQ-037 CTS deassertion mid-frame shall never abort the frame; it blocks only the next start.

Structure
REQ-038 Package uart_pkg shall hold the FSM state enum, pdsel encodings, and tick-per-bit constants (4, 16).
REQ-039 The FIFO shall be a sub-module uart_tx_fifo (DATA_W+0 wide, FIFO_DEPTH deep, level output).

Verification
REQ-040 DATA_W=8, brgh_i=1, pdsel_i=00, stsel_i=0, write 0x55 -> txd_o = 0,1,0,1,0,1,0,1,0,1, each bit 4 ticks, then tx_empty_o=1.
REQ-041 DATA_W=7, pdsel_i=10, stsel_i=1, write 0x03 -> 7 data bits 1,1,0,0,0,0,0; parity 1; two stop bits.
REQ-042 FIFO_DEPTH=4, 6 writes while busy -> tx_ready_o=0 after 5 accepted (4 queued + 1 in shifter); all 5 frames sent back-to-back in order.
REQ-043 txbrk_i=1 with 1 entry queued, DATA_W=8 -> txd_o low for 10 bit times, then one stop bit; entry discarded.
REQ-044 With UART_TX_CTS_EN, cts_i=0, write 0xA5 -> txd_o stays 1; raise cts_i -> start bit 3 cycles later; drop cts_i mid-frame -> frame completes.
REQ-045 Assert rst during DATA -> txd_o=1 immediately, fifo_level_o=0; after release, a new write transmits correctly.
